// File: rtl/braille_num_display_pkg.sv
// Shared constants, types and decode helpers for the Braille numeric display.
package braille_num_display_pkg;

  typedef logic [5:0] cell_t;
  typedef logic [3:0] glyph_t;

  localparam cell_t CellNumSign = 6'b111100;
  localparam cell_t CellSpace   = 6'b000000;
  localparam cell_t CellA       = 6'b000001;
  localparam cell_t CellB       = 6'b000011;
  localparam cell_t CellC       = 6'b001001;
  localparam cell_t CellD       = 6'b011001;
  localparam cell_t CellE       = 6'b010001;
  localparam cell_t CellF       = 6'b001011;
  localparam cell_t CellG       = 6'b011011;
  localparam cell_t CellH       = 6'b010011;
  localparam cell_t CellI       = 6'b001010;
  localparam cell_t CellJ       = 6'b011010;

  localparam glyph_t GlyphBlank = 4'hF;

  typedef enum logic [0:0] {StAlpha, StNumeric} state_e;

  typedef struct packed {
    logic   hit;
    glyph_t digit;
  } digit_t;

  // Letters a..i map to 1..9 and j maps to 0 in numeric mode.
  function automatic digit_t cell_to_digit(input cell_t c);
    digit_t r;
    r.hit   = 1'b1;
    r.digit = 4'd0;
    case (c)
      CellA:   r.digit = 4'd1;
      CellB:   r.digit = 4'd2;
      CellC:   r.digit = 4'd3;
      CellD:   r.digit = 4'd4;
      CellE:   r.digit = 4'd5;
      CellF:   r.digit = 4'd6;
      CellG:   r.digit = 4'd7;
      CellH:   r.digit = 4'd8;
      CellI:   r.digit = 4'd9;
      CellJ:   r.digit = 4'd0;
      default: r.hit   = 1'b0;
    endcase
    return r;
  endfunction

  // Active-low {a,b,c,d,e,f,g}; anything that is not a digit renders blank.
  function automatic logic [6:0] glyph_to_seg(input glyph_t g);
    logic [6:0] s;
    unique case (g)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/braille_num_display_if.sv
// Cell stream handshake between the capture front end and the display block.
interface braille_num_display_if;
  import braille_num_display_pkg::*;

  logic  cell_valid;
  cell_t cell_data;
  logic  cell_ready;

  modport master (output cell_valid, output cell_data, input cell_ready);
  modport slave  (input cell_valid, input cell_data, output cell_ready);
endinterface

// File: rtl/braille_num_display_scan.sv
// Time-multiplexed 7-segment scanner: registered an/seg for the glyph at the current index.
module braille_num_display_scan
  import braille_num_display_pkg::*;
#(
  parameter int unsigned NumDigits    = 4,
  parameter int unsigned ScanDiv      = 1000,
  parameter bit          SegActiveLow = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NumDigits-1:0][3:0]     glyphs_i,
  output logic [6:0]                    seg_o,
  output logic [NumDigits-1:0]          an_o
);

  localparam int unsigned CntW = (ScanDiv > 1) ? $clog2(ScanDiv) : 1;
  localparam int unsigned IdxW = (NumDigits > 1) ? $clog2(NumDigits) : 1;
  localparam logic [6:0]           SegOff = SegActiveLow ? 7'h7F : 7'h00;
  localparam logic [NumDigits-1:0] AnOff  = SegActiveLow ? '1 : '0;

  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [6:0]           seg_q, seg_d;
  logic [NumDigits-1:0] an_q, an_d;
  logic [NumDigits-1:0] onehot;

  always_comb begin
    cnt_d  = cnt_q + CntW'(1);
    idx_d  = idx_q;
    onehot = NumDigits'(1) << idx_q;
    if (cnt_q == CntW'(ScanDiv - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IdxW'(NumDigits - 1)) ? '0 : idx_q + IdxW'(1);
    end
    seg_d = glyph_to_seg(glyphs_i[idx_q]);
    an_d  = ~onehot;
    if (!SegActiveLow) begin
      seg_d = ~seg_d;
      an_d  = onehot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= SegOff;
      an_q  <= AnOff;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg_o = seg_q;
  assign an_o  = an_q;

endmodule

// File: rtl/braille_num_display.sv
// Braille cell stream to multiplexed 7-segment display with numeric-indicator mode tracking.
module braille_num_display
  import braille_num_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  braille_num_display_if.slave    cell_if,
  input  logic                    clear_i,
  output logic [6:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    num_mode_o,
  output logic                    err_o
);

  state_e                         state_q, state_d;
  logic [NUM_DIGITS-1:0][3:0]     glyphs_q, glyphs_d;
  logic                           err_q, err_d;
  logic                           accept;
  logic                           push;
  glyph_t                         push_glyph;
  digit_t                         dec;

  assign cell_if.cell_ready = ~rst & ~clear_i;
  assign accept = cell_if.cell_valid & cell_if.cell_ready;
  assign dec    = cell_to_digit(cell_if.cell_data);

  always_comb begin
    state_d    = state_q;
    glyphs_d   = glyphs_q;
    err_d      = 1'b0;
    push       = 1'b0;
    push_glyph = GlyphBlank;
    if (clear_i) begin
      state_d  = StAlpha;
      glyphs_d = {NUM_DIGITS{GlyphBlank}};
    end else if (accept) begin
      unique case (state_q)
        StAlpha: begin
          if (cell_if.cell_data == CellNumSign) begin
            state_d = StNumeric;
          end else if (cell_if.cell_data == CellSpace) begin
            push = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        StNumeric: begin
          if (dec.hit) begin
            push       = 1'b1;
            push_glyph = dec.digit;
          end else if (cell_if.cell_data == CellSpace) begin
            push    = 1'b1;
            state_d = StAlpha;
          end else if (cell_if.cell_data != CellNumSign) begin
            err_d   = 1'b1;
            state_d = StAlpha;
          end
        end
        default: state_d = StAlpha;
      endcase
      if (push) begin
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
          glyphs_d[i] = glyphs_q[i-1];
        end
        glyphs_d[0] = push_glyph;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StAlpha;
      glyphs_q <= {NUM_DIGITS{GlyphBlank}};
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      glyphs_q <= glyphs_d;
      err_q    <= err_d;
    end
  end

  assign num_mode_o = (state_q == StNumeric);
  assign err_o      = err_q;

  braille_num_display_scan #(
    .NumDigits    (NUM_DIGITS),
    .ScanDiv      (SCAN_DIV),
    .SegActiveLow (SEG_ACTIVE_LOW)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .glyphs_i (glyphs_q),
    .seg_o    (seg_o),
    .an_o     (an_o)
  );

endmodule

// File: tb/tb_braille_num_display.sv
// Directed and random cell streams checked against a glyph-list model of the display.
module tb_braille_num_display;

  localparam int ND = 4;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic [6:0]    seg;
  logic [ND-1:0] an;
  logic          num_mode;
  logic          err;

  braille_num_display_if bus ();

  braille_num_display #(
    .NUM_DIGITS     (ND),
    .SCAN_DIV       (SD),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cell_if    (bus),
    .clear_i    (clear),
    .seg_o      (seg),
    .an_o       (an),
    .num_mode_o (num_mode),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: glyph list (15 = blank), mode flag, expected err, edges since reset release.
  int       m_gly[ND];
  bit       m_num;
  bit       m_err;
  int       k;
  logic [6:0] pat[16];
  logic [5:0] letters[10];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ND; i++) m_gly[i] = 15;
    m_num = 0;
    m_err = 0;
    k     = 0;
  endtask

  task automatic shift_in(input int g);
    for (int i = ND - 1; i > 0; i--) m_gly[i] = m_gly[i-1];
    m_gly[0] = g;
  endtask

  task automatic model_cell(input logic [5:0] d);
    int dig;
    dig = -1;
    for (int i = 0; i < 10; i++) if (letters[i] == d) dig = (i + 1) % 10;
    m_err = 0;
    if (!m_num) begin
      if (d == 6'b111100) m_num = 1;
      else if (d == 6'b000000) shift_in(15);
      else m_err = 1;
    end else begin
      if (dig >= 0) shift_in(dig);
      else if (d == 6'b000000) begin shift_in(15); m_num = 0; end
      else if (d != 6'b111100) begin m_err = 1; m_num = 0; end
    end
  endtask

  task automatic step(input bit v, input logic [5:0] d, input bit c);
    int pre_gly[ND];
    int idx;
    bus.cell_valid = v;
    bus.cell_data  = d;
    clear          = c;
    #1;
    check("cell_ready", {31'd0, bus.cell_ready}, {31'd0, ~c});
    pre_gly = m_gly;
    @(posedge clk);
    #1;
    k++;
    if (c) begin
      model_reset_keep_scan();
    end else if (v) begin
      model_cell(d);
    end else begin
      m_err = 0;
    end
    idx = ((k - 1) / SD) % ND;
    check("num_mode", {31'd0, num_mode}, {31'd0, m_num});
    check("err", {31'd0, err}, {31'd0, m_err});
    check("an", {28'd0, an}, {28'd0, 4'b1111 ^ 4'(1 << idx)});
    check("seg", {25'd0, seg}, {25'd0, pat[pre_gly[idx]]});
  endtask

  task automatic model_reset_keep_scan();
    for (int i = 0; i < ND; i++) m_gly[i] = 15;
    m_num = 0;
    m_err = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 6'b000000, 1'b0);
  endtask

  task automatic send(input logic [5:0] d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_seg"}, {25'd0, seg}, 32'h7F);
    check({tag, "_an"}, {28'd0, an}, 32'hF);
    check({tag, "_ready"}, {31'd0, bus.cell_ready}, 32'd0);
    check({tag, "_num_mode"}, {31'd0, num_mode}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    logic [5:0] rd;
    pat[0] = 7'b0000001; pat[1] = 7'b1001111; pat[2] = 7'b0010010; pat[3] = 7'b0000110;
    pat[4] = 7'b1001100; pat[5] = 7'b0100100; pat[6] = 7'b0100000; pat[7] = 7'b0001111;
    pat[8] = 7'b0000000; pat[9] = 7'b0000100;
    for (int i = 10; i < 16; i++) pat[i] = 7'b1111111;
    letters[0] = 6'b000001; letters[1] = 6'b000011; letters[2] = 6'b001001;
    letters[3] = 6'b011001; letters[4] = 6'b010001; letters[5] = 6'b001011;
    letters[6] = 6'b011011; letters[7] = 6'b010011; letters[8] = 6'b001010;
    letters[9] = 6'b011010;
    bus.cell_valid = 1'b0;
    bus.cell_data  = 6'b000000;
    model_reset();

    // Reset held for three cycles, then scan of a blank display.
    repeat (3) @(posedge clk);
    #2;
    reset_checks("reset");
    rst = 1'b0;
    idle(17);

    // Numeric indicator then a, b.
    send(6'b111100); send(6'b000001); send(6'b000011);
    idle(16);

    // Digit 0 then a space leaves numeric mode.
    send(6'b111100); send(6'b011010); send(6'b000000);
    idle(16);

    // Rejected cells in each mode.
    send(6'b000001); idle(2);
    send(6'b111100); send(6'b111111); idle(2);
    send(6'b111100); send(6'b111100); idle(1);

    // Overflow discards the oldest glyph.
    send(6'b000000); send(6'b111100);
    for (int i = 0; i < 5; i++) send(letters[i]);
    idle(16);

    // Clear wins over a valid cell.
    step(1'b1, 6'b000001, 1'b1);
    idle(16);

    // Random stream with occasional clears.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: rd = 6'b111100;
        1: rd = 6'b000000;
        2: rd = letters[$urandom_range(0, 9)];
        default: rd = 6'($urandom);
      endcase
      step(1'($urandom), rd, $urandom_range(0, 19) == 0);
    end

    // Reset mid-number and mid-scan blanks immediately.
    send(6'b111100); send(6'b000011); step(1'b0, 6'b000000, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    reset_checks("midrst");
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    bus.cell_valid = 1'b0;
    idle(17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
